seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Time-shares the board's single 4-digit seven-segment display among up to NREQ debug sources (PC, register probe, bus monitor, etc.). Grants ownership round-robin with a minimum dwell time per owner, forwards the owner's live 16-bit value and enable to the segment scan driver, and reports the current owner back to requesters. Sits between the core's debug taps and the segment driver.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- HOLD_CYCLES, 50_000_000, minimum dwell cycles per owner before rotation (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester display request, level
- data  in  NREQ*16  requester i value at data[16*i+15:16*i]
- lock  in  1  inhibits dwell-based rotation while high
- grant  out  NREQ  one-hot current owner, all-zero when idle
- owner  out  $clog2(NREQ)  index of current owner (0 when idle)
- seg_data  out  16  value to segment driver
- seg_enable  out  1  segment driver enable

## Operation
- States: IDLE, SHOW.
- Reset (dominates all inputs, applies mid-operation): state=IDLE, grant=0, owner=0, seg_data=0, seg_enable=0, dwell counter=0, rotation pointer=NREQ-1 (so requester 0 wins first).
- Pick rule: first set req bit scanning from pointer+1 upward, wrapping modulo NREQ; pointer updated to winner on every grant.
- IDLE: req==0 → stay. Any req bit set → SHOW with picked owner, counter=0.
- SHOW, priority order per cycle:
  1. req[owner]==0 → pick among remaining req; none → IDLE (grant=0, seg_enable=0, seg_data holds last value); else new owner, counter=0.
  2. counter==HOLD_CYCLES-1, lock==0, another req bit set → rotate to picked requester (owner excluded), counter=0.
  3. otherwise counter increments, saturating at HOLD_CYCLES-1 (late arrivals rotate immediately once unlocked).
- lock does not block release in rule 1.
- In SHOW, seg_data is registered from owner's data slice every cycle (live tracking, one-cycle delay).
- Counter width $clog2(HOLD_CYCLES+1); no wrap.

## Timing
- All outputs registered.
- req rises in IDLE at cycle t → grant/owner/seg_enable valid at t+1; seg_data at t+1 = winner's data sampled at t.
- Owner drops req at t → new grant (or idle) at t+1; no cycle with two grant bits.
- Dwell: owner granted at t rotates at t+HOLD_CYCLES earliest.
- Data change at t by owner → seg_data at t+1.
- Simultaneous owner release and dwell expiry: rule 1 applies.

## Configuration
- SEG_ARB_TAG_EN defined: seg_data[15:12] replaced by owner index zero-extended to 4 bits; seg_data[11:0] from owner data; idle value unchanged (held).
- Not defined: seg_data carries owner's full 16 bits.

## Structure
- Package seg_arb_pkg: state enum typedef (IDLE, SHOW), SEG_W=16 constant.
- Sub-module seg_rr_pick: combinational round-robin picker (req vector, pointer, exclude mask → valid, index).

## Test plan
Bench: NREQ=4, HOLD_CYCLES=4.
- Reset then req=4'b0101, data0=16'h1234 → next cycle grant=0001, owner=0, seg_enable=1, seg_data=16'h1234.
- Hold req=4'b0101 → grant 0001 for 4 cycles, then 0100 for 4, then 0001 (rotation, skipping idle 1 and 3).
- lock=1 with req=4'b0011 owner 0 for 20 cycles → grant stays 0001; drop lock → grant 0010 next cycle.
- Owner 2 drops req with req=4'b0000 otherwise → next cycle grant=0, seg_enable=0, seg_data holds last value.
- Assert reset mid-SHOW at counter 2 → next cycle all outputs 0, then req=4'b1000 → grant 1000 one cycle later.
- With SEG_ARB_TAG_EN, owner 3 data=16'hABCD → seg_data=16'h3BCD.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_arb_pkg;
  localparam int SEG_W = 16;
  localparam int TAG_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;
endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first eligible request strictly after
// the pointer, wrapping modulo NREQ, with an exclude mask applied first.
module seg_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] exclude,
  output logic            valid,
  output logic [IW-1:0]   index
);

  logic [NREQ-1:0] cand;

  assign cand = req & ~exclude;

  // Scan ptr+1 .. ptr+NREQ; the first hit latches valid and freezes index.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int  pos;
      logic hit;
      pos   = (int'(ptr) + k) % NREQ;
      hit   = !valid && cand[pos];
      index = hit ? IW'(pos) : index;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit display with a minimum dwell.
// Optional macro SEG_ARB_TAG_EN: owner index replaces seg_data[15:12].
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*SEG_W-1:0]     data,
  input  logic                      lock,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [SEG_W-1:0]          seg_data,
  output logic                      seg_enable
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [CW-1:0]   dwell_r;
  logic [NREQ-1:0] exclude_s;
  logic            pick_valid_s;
  logic [IW-1:0]   pick_index_s;
  logic            take_s;
  logic            drop_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [SEG_W-1:0] seg_word(input logic [IW-1:0] idx,
                                                input logic [NREQ*SEG_W-1:0] bus);
    logic [SEG_W-1:0] w;
    w = bus[int'(idx)*SEG_W +: SEG_W];
`ifdef SEG_ARB_TAG_EN
    w[SEG_W-1 -: TAG_W] = TAG_W'(idx);
`endif
    return w;
  endfunction

  // Only the current owner is ever excluded, and only while showing.
  always_comb begin
    exclude_s = (state_r == SHOW) ? onehot(owner) : '0;
  end

  seg_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .exclude (exclude_s),
    .valid   (pick_valid_s),
    .index   (pick_index_s)
  );

  // Per-cycle decision: release has priority over dwell-expiry rotation.
  always_comb begin
    take_s = 1'b0;
    drop_s = 1'b0;
    case (state_r)
      IDLE: take_s = pick_valid_s;
      SHOW: begin
        if (!req[owner]) begin
          take_s = pick_valid_s;
          drop_s = !pick_valid_s;
        end else begin
          take_s = (dwell_r == LAST) && !lock && pick_valid_s;
        end
      end
      default: drop_s = 1'b1;
    endcase
  end

  // FSM state, dwell counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      grant      <= '0;
      owner      <= '0;
      seg_data   <= '0;
      seg_enable <= 1'b0;
      dwell_r    <= '0;
      ptr_r      <= IW'(NREQ - 1);
    end else if (take_s) begin
      state_r    <= SHOW;
      grant      <= onehot(pick_index_s);
      owner      <= pick_index_s;
      ptr_r      <= pick_index_s;
      dwell_r    <= '0;
      seg_enable <= 1'b1;
      seg_data   <= seg_word(pick_index_s, data);
    end else if (drop_s) begin
      // seg_data deliberately holds the last shown value
      state_r    <= IDLE;
      grant      <= '0;
      owner      <= '0;
      seg_enable <= 1'b0;
      dwell_r    <= '0;
    end else if (state_r == SHOW) begin
      seg_data <= seg_word(owner, data);
      if (dwell_r != LAST) begin
        dwell_r <= dwell_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (NREQ=4, HOLD_CYCLES=4) against
// a cycle-level behavioural model of ownership, dwell age and pointer.
module tb_seg_display_arbiter;

  localparam int N = 4;
  localparam int H = 4;

`ifdef SEG_ARB_TAG_EN
  localparam logic [15:0] FIRST_SEG = 16'h0234;
  localparam logic [15:0] OWN3_SEG  = 16'h3BCD;
  localparam logic [15:0] LIVE3_SEG = 16'h3111;
`else
  localparam logic [15:0] FIRST_SEG = 16'h1234;
  localparam logic [15:0] OWN3_SEG  = 16'hABCD;
  localparam logic [15:0] LIVE3_SEG = 16'h1111;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] data = 64'h0;
  logic        lock = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [15:0] seg_data;
  logic        seg_enable;

  int vectors = 0;
  int errors  = 0;

  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_age;
  logic [15:0] m_seg;

  seg_display_arbiter #(.NREQ(N), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .lock       (lock),
    .grant      (grant),
    .owner      (owner),
    .seg_data   (seg_data),
    .seg_enable (seg_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_word(input int i);
    logic [15:0] w;
    w = data[16*i +: 16];
`ifdef SEG_ARB_TAG_EN
    w[15:12] = 4'(i);
`endif
    return w;
  endfunction

  // Next requester after the last winner, never the current owner.
  function automatic int m_pick(input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i] && !(m_busy && i == m_owner)) return i;
    end
    return -1;
  endfunction

  function automatic void m_give(input int w);
    m_busy  = 1'b1;
    m_owner = w;
    m_ptr   = w;
    m_age   = 0;
    m_seg   = m_word(w);
  endfunction

  function automatic void m_step();
    int w;
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = N - 1; m_age = 0; m_seg = 16'h0;
    end else begin
      w = m_pick(req);
      if (!m_busy) begin
        if (w >= 0) m_give(w);
      end else if (!req[m_owner]) begin
        if (w >= 0) m_give(w);
        else begin m_busy = 1'b0; m_owner = 0; end
      end else if (m_age >= H - 1 && !lock && w >= 0) begin
        m_give(w);
      end else begin
        m_age++;
        m_seg = m_word(m_owner);
      end
    end
  endfunction

  function automatic logic [22:0] exp_bus();
    return {m_busy ? 4'(1 << m_owner) : 4'b0000, 2'(m_owner), m_busy, m_seg};
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; data = 64'hDEAD_BEEF_CAFE_F00D;
    tick(); tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== 23'h0) begin
      errors++; $display("FAIL reset_state: got %h want 0", {grant, owner, seg_enable, seg_data});
    end
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== exp_bus()) begin
      errors++; $display("FAIL reset_model: got %h want %h", {grant, owner, seg_enable, seg_data}, exp_bus());
    end
    reset = 1'b0; req = 4'b0000;
  endtask

  task automatic test_first_grant();
    data = 64'h0;
    data[15:0]  = 16'h1234;
    data[47:32] = 16'h5678;
    req = 4'b0101;
    tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== {4'b0001, 2'd0, 1'b1, FIRST_SEG}) begin
      errors++; $display("FAIL first_grant: got %h want %h", {grant, owner, seg_enable, seg_data},
                         {4'b0001, 2'd0, 1'b1, FIRST_SEG});
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    for (int k = 0; k < 8; k++) begin
      tick();
      want = (k < 3) ? 4'b0001 : ((k < 7) ? 4'b0100 : 4'b0001);
      vectors++;
      if (grant !== want) begin
        errors++; $display("FAIL rotation_%0d: grant %b want %b", k, grant, want);
      end
      vectors++;
      if ({grant, owner, seg_enable, seg_data} !== exp_bus()) begin
        errors++; $display("FAIL rotation_model_%0d: got %h want %h", k, {grant, owner, seg_enable, seg_data}, exp_bus());
      end
    end
  endtask

  task automatic test_lock();
    lock = 1'b1; req = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (grant !== 4'b0001) begin
        errors++; $display("FAIL lock_hold_%0d: grant %b want 0001", k, grant);
      end
    end
    lock = 1'b0;
    tick();
    vectors++;
    if ({grant, owner} !== {4'b0010, 2'd1}) begin
      errors++; $display("FAIL lock_release: grant %b owner %0d want 0010 owner 1", grant, owner);
    end
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== exp_bus()) begin
      errors++; $display("FAIL lock_model: got %h want %h", {grant, owner, seg_enable, seg_data}, exp_bus());
    end
  endtask

  task automatic test_release_idle();
    data[47:32] = 16'h2468;
    req = 4'b0100;
    tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== {4'b0100, 2'd2, 1'b1, 16'h2468}) begin
      errors++; $display("FAIL handover_2: got %h want %h", {grant, owner, seg_enable, seg_data},
                         {4'b0100, 2'd2, 1'b1, 16'h2468});
    end
    req = 4'b0000;
    data[47:32] = 16'hFFFF;
    tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== {4'b0000, 2'd0, 1'b0, 16'h2468}) begin
      errors++; $display("FAIL idle_hold: got %h want %h", {grant, owner, seg_enable, seg_data},
                         {4'b0000, 2'd0, 1'b0, 16'h2468});
    end
  endtask

  task automatic test_mid_reset();
    data[15:0] = 16'h1234;
    req = 4'b0001;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== 23'h0) begin
      errors++; $display("FAIL mid_reset: got %h want 0", {grant, owner, seg_enable, seg_data});
    end
    reset = 1'b0;
    req = 4'b1000;
    data[63:48] = 16'hABCD;
    tick();
    vectors++;
    if ({grant, owner, seg_enable, seg_data} !== {4'b1000, 2'd3, 1'b1, OWN3_SEG}) begin
      errors++; $display("FAIL after_reset_owner3: got %h want %h", {grant, owner, seg_enable, seg_data},
                         {4'b1000, 2'd3, 1'b1, OWN3_SEG});
    end
    data[63:48] = 16'h1111;
    tick();
    vectors++;
    if (seg_data !== LIVE3_SEG) begin
      errors++; $display("FAIL live_track: seg_data %h want %h", seg_data, LIVE3_SEG);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      reset = ($urandom_range(0, 79) == 0);
      data = {$urandom, $urandom};
      tick();
      vectors++;
      if ({grant, owner, seg_enable, seg_data} !== exp_bus()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", k, {grant, owner, seg_enable, seg_data}, exp_bus());
      end
    end
    reset = 1'b0;
    lock  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_lock();
    test_release_idle();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
